target_box_scheduler: RTL

- Per-frame sequencer behind the multi-target detector.
- On each frame start it snapshots the detector's 16 packed target records and qualifies each against a minimum-size filter.
- It then issues the qualifying boxes one at a time, in ascending index order, over a valid/ready stream to a downstream consumer such as the box-overlay drawer or the UART reporter.
- It reports the qualified target count and a frame-done pulse.

---
 rtl/target_box_scheduler_if.sv | 31 +++
 rtl/target_box_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/target_box_scheduler_if.sv
//------------------------------------------------------------------------------
// Module : target_box_scheduler_if
// Brief  : Box stream (valid/ready plus box payload) between scheduler and consumer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface target_box_scheduler_if #(
  parameter int IDX_W = 4
);
  logic             box_valid;
  logic             box_ready;
  logic [IDX_W-1:0] box_idx;
  logic [9:0]       box_xmin;
  logic [9:0]       box_ymin;
  logic [9:0]       box_xmax;
  logic [9:0]       box_ymax;
  logic             box_last;

  modport master (
    output box_valid, box_idx, box_xmin, box_ymin, box_xmax, box_ymax, box_last,
    input  box_ready
  );

  modport slave (
    input  box_valid, box_idx, box_xmin, box_ymin, box_xmax, box_ymax, box_last,
    output box_ready
  );
endinterface

`default_nettype wire

// File: rtl/target_box_scheduler.sv
//------------------------------------------------------------------------------
// Module : target_box_scheduler
// Brief  : Snapshots target records per frame, filters by size, streams boxes out.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module target_box_scheduler #(
  parameter int N_TGT = 16,
  parameter int IDX_W = 4,
  parameter int REC_W = 41
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   frame_start,
  input  logic [N_TGT*REC_W-1:0] tgt_pos_flat,
  input  logic [9:0]             min_w,
  input  logic [9:0]             min_h,
  target_box_scheduler_if.master bus,
  output logic [IDX_W:0]         target_cnt,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_overrun
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_QUAL = 3'd1,
    S_SCAN = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next;

  logic [N_TGT*REC_W-1:0] r_snap;
  logic [9:0]             r_min_w;
  logic [9:0]             r_min_h;
  logic [N_TGT-1:0]       r_mask;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W:0]         r_cnt;
  logic [IDX_W-1:0]       r_box_idx;
  logic [9:0]             r_xmin;
  logic [9:0]             r_ymin;
  logic [9:0]             r_xmax;
  logic [9:0]             r_ymax;
  logic                   r_last;
  logic                   r_ovr;

  logic [N_TGT-1:0]       w_qual;
  logic [IDX_W:0]         w_pop;
  logic [REC_W-1:0]       w_cur;
  logic                   w_higher;
  logic                   w_idx_max;

  // Widths/heights are formed at 11 bits so a full-span 1024-pixel box cannot wrap.
  for (genvar gi = 0; gi < N_TGT; gi++) begin : g_qual
    logic [REC_W-1:0] w_rec;
    logic [10:0]      w_wid;
    logic [10:0]      w_hgt;
    assign w_rec = r_snap[gi*REC_W +: REC_W];
    assign w_wid = {1'b0, w_rec[29:20]} - {1'b0, w_rec[9:0]} + 11'd1;
    assign w_hgt = {1'b0, w_rec[39:30]} - {1'b0, w_rec[19:10]} + 11'd1;
    assign w_qual[gi] = w_rec[40]
                      & (w_rec[29:20] >= w_rec[9:0])
                      & (w_rec[39:30] >= w_rec[19:10])
                      & (w_wid >= {1'b0, r_min_w})
                      & (w_hgt >= {1'b0, r_min_h});
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_TGT; i++) begin
      w_pop = w_pop + {{IDX_W{1'b0}}, w_qual[i]};
    end
  end

  // Any qualifying record above the current index decides box_last.
  always_comb begin
    w_higher = 1'b0;
    for (int i = 0; i < N_TGT; i++) begin
      if (i > int'(r_idx)) begin
        w_higher = w_higher | r_mask[i];
      end
    end
  end

  assign w_cur     = r_snap[int'(r_idx)*REC_W +: REC_W];
  assign w_idx_max = (r_idx == IDX_W'(N_TGT-1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_next = S_QUAL;
        end
      end
      S_QUAL: begin
        w_next = S_SCAN;
      end
      S_SCAN: begin
        if (r_mask == '0) begin
          w_next = S_DONE;
        end else if (r_mask[r_idx]) begin
          w_next = S_SEND;
        end else if (w_idx_max) begin
          w_next = S_DONE;
        end
      end
      S_SEND: begin
        if (bus.box_ready) begin
          w_next = r_last ? S_DONE : S_SCAN;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_snap    <= '0;
      r_min_w   <= '0;
      r_min_h   <= '0;
      r_mask    <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_box_idx <= '0;
      r_xmin    <= '0;
      r_ymin    <= '0;
      r_xmax    <= '0;
      r_ymax    <= '0;
      r_last    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_ovr <= frame_start & (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_snap  <= tgt_pos_flat;
            r_min_w <= min_w;
            r_min_h <= min_h;
          end
        end
        S_QUAL: begin
          r_mask <= w_qual;
          r_cnt  <= w_pop;
          r_idx  <= '0;
        end
        S_SCAN: begin
          if (r_mask != '0) begin
            if (r_mask[r_idx]) begin
              r_box_idx <= r_idx;
              r_xmin    <= w_cur[9:0];
              r_ymin    <= w_cur[19:10];
              r_xmax    <= w_cur[29:20];
              r_ymax    <= w_cur[39:30];
              r_last    <= ~w_higher;
            end else if (!w_idx_max) begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_SEND: begin
          if (bus.box_ready && !r_last) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.box_valid = (r_state == S_SEND);
  assign bus.box_idx   = r_box_idx;
  assign bus.box_xmin  = r_xmin;
  assign bus.box_ymin  = r_ymin;
  assign bus.box_xmax  = r_xmax;
  assign bus.box_ymax  = r_ymax;
  assign bus.box_last  = r_last;

  assign target_cnt    = r_cnt;
  assign busy          = (r_state != S_IDLE);
  assign frame_done    = (r_state == S_DONE);
  assign frame_overrun = r_ovr;

endmodule

`default_nettype wire
